// File: rtl/self_eb_data.sv
// Two-entry elastic buffer (main + skid) with valid/stop handshake on both sides,
// registered outputs, and a saturating back-pressure cycle counter.
module self_eb_data #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             iv_l,
  output logic             is_l,
  input  logic [WIDTH-1:0] id_l,
  output logic             ov_r,
  input  logic             os_r,
  output logic [WIDTH-1:0] od_r,
  output logic [CNT_W-1:0] stall_cnt
);

  // state | meaning
  // EMPTY | no token held, ov_r=0
  // HALF  | one token in main reg (od_r)
  // FULL  | main and skid both hold tokens, is_l=1
  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    HALF  = 2'd1,
    FULL  = 2'd2
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic [WIDTH-1:0] skid;
  logic             in_x;
  logic             out_x;

  assign in_x  = iv_l & ~is_l;
  assign out_x = ov_r & ~os_r;

  always_comb begin
    state_nxt = state;
    case (state)
      EMPTY: if (in_x) state_nxt = HALF;
      HALF: begin
        if (in_x && !out_x)      state_nxt = FULL;
        else if (!in_x && out_x) state_nxt = EMPTY;
      end
      FULL:  if (out_x) state_nxt = HALF;
      default: state_nxt = EMPTY;
    endcase
  end

  // Handshake outputs are registered from the next state so no stop path is combinational.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= EMPTY;
      ov_r  <= 1'b0;
      is_l  <= 1'b0;
      od_r  <= '0;
      skid  <= '0;
    end else begin
      state <= state_nxt;
      ov_r  <= (state_nxt != EMPTY);
      is_l  <= (state_nxt == FULL);
      case (state)
        EMPTY: if (in_x) od_r <= id_l;
        HALF: begin
          if (in_x && out_x)       od_r <= id_l;
          else if (in_x && !out_x) skid <= id_l;
        end
        FULL:  if (out_x) od_r <= skid;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stall_cnt <= '0;
    end else if (ov_r && os_r && (stall_cnt != {CNT_W{1'b1}})) begin
      stall_cnt <= stall_cnt + CNT_W'(1);
    end
  end

endmodule
